// File: rtl/axi_wr_slave_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_wr_pkg
// Description : Shared types and constants for the AXI write-channel slave:
//               FSM state encoding, B-channel response codes and the
//               per-beat address increment helper.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_wr_pkg;

    // Burst-level FSM: address phase, data streaming, write response
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Byte distance between consecutive beats for a given log2 beat size
    function automatic int unsigned beat_incr(input int unsigned level);
        return 32'd1 << level;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_wr_slave_if.sv
`default_nettype none
// ============================================================================
// Module      : axi_wr_slave_if
// Description : AXI write-channel (AW/W/B) plus controller-core req/ack bus
//               bundled into one interface. The slave modport is the DDR2
//               side of the link, the master modport is the AXI master and
//               core-side driver.
// Revision    : 1.0 - initial release
// ============================================================================
interface axi_wr_slave_if #(
    parameter int ADDR_WIDTH = 27,
    parameter int DATA_WIDTH = 32
);
    logic                  awvalid;
    logic                  awready;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [7:0]            awlen;
    logic                  wvalid;
    logic                  wready;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  wlast;
    logic                  bvalid;
    logic                  bready;
    logic [1:0]            bresp;
    logic                  wr_req;
    logic                  wr_ack;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_last;

    modport slave (
        input  awvalid, awaddr, awlen, wvalid, wdata, wlast, bready, wr_ack,
        output awready, wready, bvalid, bresp, wr_req, wr_addr, wr_data, wr_last
    );

    modport master (
        output awvalid, awaddr, awlen, wvalid, wdata, wlast, bready, wr_ack,
        input  awready, wready, bvalid, bresp, wr_req, wr_addr, wr_data, wr_last
    );
endinterface
`default_nettype wire

// File: rtl/axi_wr_slave_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with first-word fall-through output (dout
//               always shows the head entry). Pointers carry one extra wrap
//               bit so full and empty are distinguishable at equal indices.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             push,
    input  wire logic             pop,
    input  wire logic [WIDTH-1:0] din,
    output logic      [WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PTR_W:0]   r_wr_ptr_q, w_wr_ptr_d;
    logic [PTR_W:0]   r_rd_ptr_q, w_rd_ptr_d;
    logic [WIDTH-1:0] r_mem_q [DEPTH];
    logic             w_do_push;
    logic             w_do_pop;

    // Status flags, guarded push/pop and the fall-through head
    always_comb begin
        empty     = (r_wr_ptr_q == r_rd_ptr_q);
        full      = (r_wr_ptr_q[PTR_W] != r_rd_ptr_q[PTR_W]) &&
                    (r_wr_ptr_q[PTR_W-1:0] == r_rd_ptr_q[PTR_W-1:0]);
        w_do_push = push && !full;
        w_do_pop  = pop && !empty;
        dout      = r_mem_q[r_rd_ptr_q[PTR_W-1:0]];
    end

    // Pointer advance on accepted push/pop
    always_comb begin
        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        if (w_do_push) w_wr_ptr_d = r_wr_ptr_q + 1'b1;
        if (w_do_pop)  w_rd_ptr_d = r_rd_ptr_q + 1'b1;
    end

    // Pointer registers; reset flushes the contents by equalising pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
        end else begin
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
        end
    end

    // Storage array, written at the tail slot
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem_q[r_wr_ptr_q[PTR_W-1:0]] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/axi_wr_slave.sv
`default_nettype none
// ============================================================================
// Module      : axi_wr_slave
// Description : AXI write-channel slave for the DDR2 controller. Takes one
//               AW burst at a time, buffers W beats in a FIFO, streams them
//               to the core over req/ack with incrementing byte addresses,
//               then returns a B response once every beat has been acked.
//               Optional macro AXIWR_LAST_CHECK_EN enables wlast checking:
//               early wlast truncates the burst, a missing wlast on the
//               final beat is flagged, both reported as SLVERR.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_wr_slave
    import axi_wr_pkg::*;
#(
    parameter int ADDR_WIDTH = 27,   // ROW_BITS + COL_BITS + BA_BITS
    parameter int DATA_WIDTH = 32,   // DQ_BITS * 2
    parameter int DATA_LEVEL = 2,
    parameter int FIFO_DEPTH = 16
) (
    input  wire logic      clk,
    input  wire logic      rst,
    axi_wr_slave_if.slave  bus
);
    localparam logic [ADDR_WIDTH-1:0] C_ADDR_INCR =
        ADDR_WIDTH'(beat_incr(DATA_LEVEL));

    state_t                r_state_q,   w_state_d;
    logic [ADDR_WIDTH-1:0] r_addr_q,    w_addr_d;
    logic [7:0]            r_len_q,     w_len_d;
    logic [8:0]            r_in_cnt_q,  w_in_cnt_d;
    logic [8:0]            r_out_cnt_q, w_out_cnt_d;
`ifdef AXIWR_LAST_CHECK_EN
    logic                  r_err_q,     w_err_d;
`endif

    logic                  w_push;
    logic                  w_pop;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [DATA_WIDTH-1:0] w_fifo_dout;
    logic [8:0]            w_len_ext;
    logic                  w_is_last;

    assign w_len_ext = {1'b0, r_len_q};
    assign w_is_last = (r_out_cnt_q == w_len_ext);
    assign w_push    = bus.wvalid && bus.wready;
    assign w_pop     = bus.wr_ack && bus.wr_req;

    sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (bus.wdata),
        .dout  (w_fifo_dout),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    // State and burst bookkeeping registers; reset abandons any burst
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q   <= IDLE;
            r_addr_q    <= '0;
            r_len_q     <= '0;
            r_in_cnt_q  <= '0;
            r_out_cnt_q <= '0;
`ifdef AXIWR_LAST_CHECK_EN
            r_err_q     <= 1'b0;
`endif
        end else begin
            r_state_q   <= w_state_d;
            r_addr_q    <= w_addr_d;
            r_len_q     <= w_len_d;
            r_in_cnt_q  <= w_in_cnt_d;
            r_out_cnt_q <= w_out_cnt_d;
`ifdef AXIWR_LAST_CHECK_EN
            r_err_q     <= w_err_d;
`endif
        end
    end

    // Next-state, counter and address generation
    always_comb begin
        w_state_d   = r_state_q;
        w_addr_d    = r_addr_q;
        w_len_d     = r_len_q;
        w_in_cnt_d  = r_in_cnt_q;
        w_out_cnt_d = r_out_cnt_q;
`ifdef AXIWR_LAST_CHECK_EN
        w_err_d     = r_err_q;
`endif
        case (r_state_q)
            IDLE: begin
`ifdef AXIWR_LAST_CHECK_EN
                w_err_d = 1'b0;
`endif
                if (bus.awvalid && bus.awready) begin
                    w_addr_d    = bus.awaddr;
                    w_len_d     = bus.awlen;
                    w_in_cnt_d  = '0;
                    w_out_cnt_d = '0;
                    w_state_d   = DATA;
                end
            end
            DATA: begin
                if (w_push) begin
                    w_in_cnt_d = r_in_cnt_q + 9'd1;
`ifdef AXIWR_LAST_CHECK_EN
                    // Early wlast shortens the burst to the beat just taken
                    if (bus.wlast && (r_in_cnt_q < w_len_ext)) begin
                        w_len_d = r_in_cnt_q[7:0];
                        w_err_d = 1'b1;
                    end else if (!bus.wlast && (r_in_cnt_q == w_len_ext)) begin
                        w_err_d = 1'b1;
                    end
`endif
                end
                if (w_pop) begin
                    w_out_cnt_d = r_out_cnt_q + 9'd1;
                    w_addr_d    = r_addr_q + C_ADDR_INCR;
                    if (w_is_last) w_state_d = RESP;
                end
            end
            RESP: begin
                if (bus.bvalid && bus.bready) w_state_d = IDLE;
            end
            default: w_state_d = IDLE;
        endcase
    end

    // Handshake and core-side outputs decoded from the current state
    always_comb begin
        bus.awready = (r_state_q == IDLE) && !rst;
        bus.wready  = (r_state_q == DATA) && !rst && !w_fifo_full &&
                      (r_in_cnt_q <= w_len_ext);
        bus.bvalid  = (r_state_q == RESP);
`ifdef AXIWR_LAST_CHECK_EN
        bus.bresp   = ((r_state_q == RESP) && r_err_q) ? RESP_SLVERR : RESP_OKAY;
`else
        bus.bresp   = RESP_OKAY;
`endif
        bus.wr_req  = (r_state_q == DATA) && !w_fifo_empty;
        bus.wr_addr = r_addr_q;
        bus.wr_data = w_fifo_dout;
        bus.wr_last = (r_state_q == DATA) && w_is_last;
    end

endmodule
`default_nettype wire

// File: doc/axi_wr_slave.md
Name: axi_wr_slave

Overview:
- AXI write-channel slave on the DDR2 controller side; the downstream consumer of the testbench AXI write master.
- Accepts one AW burst at a time and buffers W beats in an internal FIFO.
- Streams beats with incrementing addresses to the controller core over a req/ack interface.
- Returns a B response once every beat of the burst has been acked by the core.

Parameters:
- ADDR_WIDTH, `ROW_BITS+`COL_BITS+`BA_BITS: byte address width.
- DATA_WIDTH, `DQ_BITS*2: beat width.
- DATA_LEVEL, 2: log2 of the per-beat address increment (increment = 1<<DATA_LEVEL).
- FIFO_DEPTH, 16: W-beat buffer depth; power of two, at least 2.

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous active-high reset
- awvalid  in  1  AW valid
- awready  out  1  AW ready
- awaddr  in  ADDR_WIDTH  burst start address
- awlen  in  8  beats minus 1
- wvalid  in  1  W valid
- wready  out  1  W ready
- wdata  in  DATA_WIDTH  write beat
- wlast  in  1  last beat marker
- bvalid  out  1  response valid
- bready  in  1  response ready
- bresp  out  2  00 OKAY, 10 SLVERR
- wr_req  out  1  beat available to core
- wr_ack  in  1  core consumes current beat
- wr_addr  out  ADDR_WIDTH  beat byte address
- wr_data  out  DATA_WIDTH  beat data (FIFO head)
- wr_last  out  1  final beat of the burst

Behaviour:
- Reset: all sampled on a clk edge with rst=1; rst wins over every other event.
  - awready=0, wready=0, bvalid=0, bresp=00, wr_req=0, wr_addr=0, wr_last=0.
  - FIFO flushed, FSM forced to IDLE.
  - Reset mid-burst discards everything buffered, with no B response.
  - awready=1 on the first cycle after rst deasserts.
- FSM states IDLE, DATA, RESP:
  - IDLE: awready=1. On awvalid&awready, latch awaddr into the address counter, latch awlen, clear the in-beat and out-beat counters, go to DATA.
  - DATA: wready = !fifo_full && (in_cnt <= len). Each wvalid&wready pushes wdata and increments in_cnt (9-bit). Go to RESP when the final pushed beat has been popped with wr_ack.
  - RESP: bvalid=1 and bresp held stable until bready. On bvalid&bready, go to IDLE (awready=1 the next cycle). bvalid may stay high indefinitely.
  - awready=0 and wready=0 outside IDLE and DATA respectively; W beats presented in IDLE are not accepted.
- Core side:
  - wr_req = FIFO not empty, in DATA.
  - wr_data = FIFO head.
  - wr_last = (out_cnt == len).
  - wr_ack is honoured only when wr_req=1. Each ack pops one beat, increments out_cnt, and adds 1<<DATA_LEVEL to wr_addr, modulo 2^ADDR_WIDTH (silent wrap).
- Latency: a beat pushed at edge N gives wr_req=1 after edge N. The final wr_ack at edge M gives bvalid=1 after edge M.
- Full/empty: push and pop in the same cycle are legal at any occupancy, including full (wready is low when full, so no push then). Occupancy is unchanged on a simultaneous push and pop.
- wlast handling with the feature compiled out: wlast is ignored; the burst is exactly awlen+1 beats and bresp=00.

Optional Feature:
- Macro: AXIWR_LAST_CHECK_EN.
- Defined:
  - Early wlast (in_cnt < len): this beat is treated as the last one, len is truncated to in_cnt, wr_last goes on that beat, bresp=10.
  - Missing wlast on beat awlen+1: the burst still ends there, bresp=10.
  - The error flag is sticky per burst and cleared in IDLE.
- Undefined: no checking logic is present and bresp is constant 00.

Decomposition:
- Package axi_wr_pkg:
  - state enum {IDLE, DATA, RESP}
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10
  - function for the beat increment from DATA_LEVEL
- Sub-module sync_fifo: parameters WIDTH and DEPTH; ports push, pop, din, dout, full, empty; dout shows the head with no read latency. FSM, counters and address generation stay in axi_wr_slave.

Test Plan:
- Basic burst: awaddr=0, awlen=7, wdata=0,4,...,28, wr_ack tied 1 -> wr_addr 0,4,...,28; wr_last only on the 8th beat; bvalid one cycle after the last ack with bresp=00.
- Backpressure: awlen=31, wr_ack=0 -> exactly 16 beats accepted, then wready=0. Release wr_ack -> all 32 beats emerge in order, no loss or duplication, bresp=00.
- Single beat and wrap: awaddr=2^ADDR_WIDTH-4, awlen=1 -> wr_addr = max-3, then 0. awlen=0 -> one beat with wr_last=1.
- B stall: hold bready=0 for 5 cycles -> bvalid and bresp stable; awready=0 throughout; awready=1 the cycle after the handshake.
- Reset mid-burst: rst after 3 of 8 beats -> all outputs 0 next cycle, FIFO empty, no bvalid. A fresh burst afterwards completes with OKAY.
- With AXIWR_LAST_CHECK_EN: awlen=7 with wlast on beat 4 -> only 4 beats forwarded, wr_last on the 4th, bresp=10. Without wlast on beat 8 -> 8 beats forwarded, bresp=10.
